// File: rtl/vga_sync_gen.sv
// Raster timing generator: free-running H/V counters address the glyph reader, and
// the returned pixel is registered together with HSync/VSync/VideoOn so all pins align.
module vga_sync_gen #(
  parameter int unsigned HVisible = 640,
  parameter int unsigned HFront   = 16,
  parameter int unsigned HSyncW   = 96,
  parameter int unsigned HBack    = 42,
  parameter int unsigned VVisible = 480,
  parameter int unsigned VFront   = 10,
  parameter int unsigned VSyncW   = 2,
  parameter int unsigned VBack    = 31,
  parameter logic [11:0] ColorFG  = 12'hFFF,
  parameter logic [11:0] ColorBG  = 12'h000
) (
  input  logic        Reloj,
  input  logic        Reset,
  input  logic        PixelEn,
  input  logic        Pixel,
  output logic [10:0] Fila,
  output logic [10:0] Columna,
  output logic        HSync,
  output logic        VSync,
  output logic        VideoOn,
  output logic [3:0]  R,
  output logic [3:0]  G,
  output logic [3:0]  B,
  output logic        FrameStart
);

  localparam int unsigned HTotal = HVisible + HFront + HSyncW + HBack;
  localparam int unsigned VTotal = VVisible + VFront + VSyncW + VBack;

  localparam logic [10:0] HLast = 11'(HTotal - 1);
  localparam logic [10:0] VLast = 11'(VTotal - 1);

  // 12-bit bounds so an end-of-sync equal to 2048 still compares correctly.
  localparam logic [11:0] HVisEnd    = 12'(HVisible);
  localparam logic [11:0] HSyncStart = 12'(HVisible + HFront);
  localparam logic [11:0] HSyncEnd   = 12'(HVisible + HFront + HSyncW);
  localparam logic [11:0] VVisEnd    = 12'(VVisible);
  localparam logic [11:0] VSyncStart = 12'(VVisible + VFront);
  localparam logic [11:0] VSyncEnd   = 12'(VVisible + VFront + VSyncW);

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        video_on_q, video_on_d;
  logic [11:0] rgb_q, rgb_d;
  logic        frame_start_q;

  logic [11:0] hcount_ext, vcount_ext;
  logic        h_last, v_last;

  assign hcount_ext = {1'b0, hcount_q};
  assign vcount_ext = {1'b0, vcount_q};
  assign h_last     = (hcount_q == HLast);
  assign v_last     = (vcount_q == VLast);

  always_comb begin
    hcount_d = h_last ? 11'd0 : hcount_q + 11'd1;
    vcount_d = vcount_q;
    if (h_last) begin
      vcount_d = v_last ? 11'd0 : vcount_q + 11'd1;
    end

    video_on_d = (hcount_ext < HVisEnd) && (vcount_ext < VVisEnd);
    rgb_d      = 12'h000;
    if (video_on_d) begin
      rgb_d = Pixel ? ColorFG : ColorBG;
    end
    hsync_d = !((hcount_ext >= HSyncStart) && (hcount_ext < HSyncEnd));
    vsync_d = !((vcount_ext >= VSyncStart) && (vcount_ext < VSyncEnd));
  end

  always_ff @(posedge Reloj) begin
    if (Reset) begin
      hcount_q      <= 11'd0;
      vcount_q      <= 11'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      rgb_q         <= 12'h000;
      frame_start_q <= 1'b0;
    end else begin
      // Updated every clock so the pulse is one clock wide whatever the enable duty.
      frame_start_q <= PixelEn && h_last && v_last;
      if (PixelEn) begin
        hcount_q   <= hcount_d;
        vcount_q   <= vcount_d;
        hsync_q    <= hsync_d;
        vsync_q    <= vsync_d;
        video_on_q <= video_on_d;
        rgb_q      <= rgb_d;
      end
    end
  end

  assign Fila       = vcount_q;
  assign Columna    = hcount_q;
  assign HSync      = hsync_q;
  assign VSync      = vsync_q;
  assign VideoOn    = video_on_q;
  assign {R, G, B}  = rgb_q;
  assign FrameStart = frame_start_q;

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Raster timing generator for the VGA text path. Free-running horizontal/vertical counters drive the `Fila`/`Columna` address consumed by the glyph-memory reader. The block then samples that reader's combinational `Pixel` and produces registered, mutually aligned `HSync`/`VSync`/RGB for the DAC pins. It sits directly upstream (address) and downstream (pixel) of the glyph-memory reader.

## Interface
Parameters:
- `HVisible`, 640: visible columns
- `HFront`, 16: horizontal front porch
- `HSyncW`, 96: horizontal sync width
- `HBack`, 42: horizontal back porch (total 794)
- `VVisible`, 480: visible lines
- `VFront`, 10: vertical front porch
- `VSyncW`, 2: vertical sync width
- `VBack`, 31: vertical back porch (total 523)
- `ColorFG`, 12'hFFF: RGB444 for `Pixel`=1
- `ColorBG`, 12'h000: RGB444 for `Pixel`=0 inside the visible area

Ports:
- `Reloj` in 1: system clock
- `Reset` in 1: synchronous, active-high reset
- `PixelEn` in 1: pixel-rate enable; all state advances only when high
- `Pixel` in 1: glyph bit for the current `Fila`/`Columna`, combinational from the reader
- `Fila` out 11: current line, 0..VTotal-1
- `Columna` out 11: current column, 0..HTotal-1
- `HSync` out 1: horizontal sync, active low
- `VSync` out 1: vertical sync, active low
- `VideoOn` out 1: registered visible-area flag, aligned with RGB
- `R`, `G`, `B` out 4 each: registered colour
- `FrameStart` out 1: one-`Reloj` pulse at each frame wrap

## Operation
- Totals:
  - HTotal = HVisible+HFront+HSyncW+HBack.
  - VTotal likewise.
  - Defaults give 794×523. Any parameter set with HTotal or VTotal > 2048 is illegal.
- Stage 0 counters, updated only on `Reloj` edges with `PixelEn`=1:
  - HCount increments and wraps HTotal-1 → 0.
  - On that wrap VCount increments, wrapping VTotal-1 → 0.
  - `Fila`=VCount and `Columna`=HCount, driven directly from the counter registers.
- Stage 1 outputs, registered on the same `PixelEn` edges from stage-0 values:
  - Vis = HCount<HVisible && VCount<VVisible.
  - `VideoOn` <= Vis.
  - {R,G,B} <= Vis ? (`Pixel` ? ColorFG : ColorBG) : 12'h000.
  - `HSync` <= !(HCount ≥ HVisible+HFront && HCount < HVisible+HFront+HSyncW).
  - `VSync` <= !(VCount ≥ VVisible+VFront && VCount < VVisible+VFront+VSyncW), evaluated on the current VCount, so the vertical pulse spans whole lines.
- `FrameStart`:
  - Registered <= 1 on the `PixelEn` edge where HCount=HTotal-1 and VCount=VTotal-1; otherwise <= 0.
  - It is updated every `Reloj`, so it is exactly one `Reloj` wide regardless of `PixelEn` duty.
- `Pixel` out-of-area values are ignored (blanked to 0).

## Timing
- Reset (synchronous, priority over `PixelEn`) forces, on the next `Reloj` edge:
  - HCount=0, VCount=0 (`Fila`=`Columna`=0).
  - `HSync`=1, `VSync`=1, `VideoOn`=0, R=G=B=0, `FrameStart`=0.
- Reset mid-frame: the raster restarts at (0,0) on the next `PixelEn` edge after release. No partial sync pulse is held.
- Latency: `Pixel` sampled for address (F,C) appears on RGB one `PixelEn` step later. `HSync`, `VSync` and `VideoOn` carry the same one-step delay, so all pin outputs are mutually aligned.
- `PixelEn`=0: every register holds, except `FrameStart`, which clears.
- `PixelEn` tied high: one pixel per `Reloj`.
- Line period = HTotal enabled cycles; frame period = HTotal·VTotal enabled cycles (415,262 at defaults).
- HSync low for HSyncW enabled cycles per line. VSync low for VSyncW full lines per frame.
- Simultaneous H and V wrap at (793,522) → (0,0) happens in a single edge, with `FrameStart` asserted on that edge.

## Test plan
- Reset behaviour: hold `Reset` 3 cycles with `PixelEn`=1 → `Fila`=`Columna`=0, `HSync`=`VSync`=1, RGB=0, `FrameStart`=0. Release → `Columna` reads 1 after the first enabled edge.
- Horizontal timing: `PixelEn`=1, one line → `HSync` low exactly 96 cycles, the first low edge following stage-0 `Columna`=656. `Columna` wraps 793→0 while `Fila` goes 0→1.
- Full frame: run one frame → `FrameStart` pulses once per 415,262 cycles. `VSync` low for 2×794 cycles, beginning in the cycle after stage-0 (`Fila`=490, `Columna`=0). `Fila` maxes at 522.
- Pixel gating: force `Pixel`=1 → RGB=12'hFFF exactly while `VideoOn`=1 (640×480 pixels/frame), else 0. `Pixel`=0 in the visible area → 12'h000.
- Enable throttling: `PixelEn` high every 2nd cycle → counters step every 2 `Reloj` cycles and the frame takes 830,524 cycles. `FrameStart` stays one `Reloj` wide.
- Mid-frame reset: assert `Reset` at `Fila`=300, `Columna`=700 (inside HSync) → next edge `HSync`=1 and counters 0. The following frame timing is identical to a fresh start.
